// File: rtl/kn_coloring_checker.sv
// Sequential graph-colouring validator: complete-graph sweep or streamed edge list.
// Reports validity, saturating conflict count and the first conflicting edge.
module kn_coloring_checker #(
    parameter int N_VERT  = 5,
    parameter int COLOR_W = 3,
    parameter int CNT_W   = 16,
    localparam int VID_W  = (N_VERT > 1) ? $clog2(N_VERT) : 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        mode,
    input  logic [N_VERT*COLOR_W-1:0]   colors,
    input  logic                        edge_valid,
    output logic                        edge_ready,
    input  logic [VID_W-1:0]            edge_u,
    input  logic [VID_W-1:0]            edge_v,
    input  logic                        edge_last,
    output logic                        busy,
    output logic                        done,
    output logic                        valid_coloring,
    output logic [CNT_W-1:0]            conflict_count,
    output logic [VID_W-1:0]            first_u,
    output logic [VID_W-1:0]            first_v,
    output logic                        edge_err
);

    typedef enum logic [1:0] {IDLE, SWEEP, STREAM, DONE} state_t;

    localparam logic [VID_W-1:0] V_LAST = VID_W'(N_VERT - 1);
    localparam logic [VID_W-1:0] I_LAST = VID_W'(N_VERT - 2);

    state_t                      state, state_d;
    logic [N_VERT*COLOR_W-1:0]   col_q;
    logic [VID_W-1:0]            i_q, i_d, j_q, j_d;
    logic [CNT_W-1:0]            cnt_d;
    logic [VID_W-1:0]            fu_d, fv_d;
    logic                        err_d;
    logic [VID_W-1:0]            sel_a, sel_b;
    logic                        cmp, bad;

    function automatic logic [COLOR_W-1:0] pick(
        input logic [N_VERT*COLOR_W-1:0] c,
        input logic [VID_W-1:0]          k
    );
        pick = '0;
        for (int v = 0; v < N_VERT; v++)
            if (k == VID_W'(v))
                pick = c[v*COLOR_W +: COLOR_W];
    endfunction

    assign busy       = (state == SWEEP) || (state == STREAM);
    assign done       = (state == DONE);
    assign edge_ready = (state == STREAM);

    assign sel_a = (state == SWEEP) ? i_q : edge_u;
    assign sel_b = (state == SWEEP) ? j_q : edge_v;
    // Out-of-range indices never reach the colour compare.
    assign bad = (edge_u == edge_v) || (32'(edge_u) >= N_VERT)
              || (32'(edge_v) >= N_VERT);

    always_comb begin
        state_d = state;
        i_d     = i_q;
        j_d     = j_q;
        cnt_d   = conflict_count;
        fu_d    = first_u;
        fv_d    = first_v;
        err_d   = edge_err;
        cmp     = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    cnt_d = '0;
                    fu_d  = '0;
                    fv_d  = '0;
                    err_d = 1'b0;
                    i_d   = '0;
                    j_d   = VID_W'(1);
                    if (mode)
                        state_d = STREAM;
                    else if (N_VERT == 1)
                        state_d = DONE;
                    else
                        state_d = SWEEP;
                end
            end
            SWEEP: begin
                cmp = 1'b1;
                if (j_q == V_LAST) begin
                    if (i_q == I_LAST) begin
                        state_d = DONE;
                    end else begin
                        i_d = i_q + VID_W'(1);
                        j_d = i_q + VID_W'(2);
                    end
                end else begin
                    j_d = j_q + VID_W'(1);
                end
            end
            STREAM: begin
                if (edge_valid) begin
                    cmp = ~bad;
                    if (bad)
                        err_d = 1'b1;
                    if (edge_last)
                        state_d = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (cmp && (pick(col_q, sel_a) == pick(col_q, sel_b))) begin
            if (conflict_count == '0) begin
                fu_d = sel_a;
                fv_d = sel_b;
            end
            if (conflict_count != '1)
                cnt_d = conflict_count + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            col_q          <= '0;
            i_q            <= '0;
            j_q            <= '0;
            conflict_count <= '0;
            first_u        <= '0;
            first_v        <= '0;
            edge_err       <= 1'b0;
            valid_coloring <= 1'b0;
        end else begin
            state          <= state_d;
            i_q            <= i_d;
            j_q            <= j_d;
            conflict_count <= cnt_d;
            first_u        <= fu_d;
            first_v        <= fv_d;
            edge_err       <= err_d;
            if ((state == IDLE) && start)
                col_q <= colors;
            // Result is settled on entry to DONE so it is visible with done.
            if (state_d == DONE)
                valid_coloring <= (cnt_d == '0) & ~err_d;
            else if ((state == IDLE) && start)
                valid_coloring <= 1'b0;
        end
    end

endmodule

// File: tb/tb_kn_coloring_checker.sv
// Scoreboard bench for kn_coloring_checker: sweep, stream, saturation, reset abort.
module tb_kn_coloring_checker;

    localparam int N  = 5;
    localparam int CW = 3;
    localparam int P  = N * (N - 1) / 2;

    logic        clk, rst_n, start, mode;
    logic [14:0] colors;
    logic        edge_valid, edge_last;
    logic [2:0]  edge_u, edge_v;

    logic        edge_ready, busy, done, valid_coloring, edge_err;
    logic [15:0] conflict_count;
    logic [2:0]  first_u, first_v;

    logic        rdy2, busy2, done2, valid2, err2;
    logic [1:0]  cnt2;
    logic [2:0]  fu2, fv2;

    typedef struct {
        logic [23:0] res;
        logic [1:0]  cnt2;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   passed = 0;
    int   total  = 0;

    kn_coloring_checker #(.N_VERT(N), .COLOR_W(CW), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .colors(colors),
        .edge_valid(edge_valid), .edge_ready(edge_ready), .edge_u(edge_u),
        .edge_v(edge_v), .edge_last(edge_last), .busy(busy), .done(done),
        .valid_coloring(valid_coloring), .conflict_count(conflict_count),
        .first_u(first_u), .first_v(first_v), .edge_err(edge_err)
    );

    kn_coloring_checker #(.N_VERT(N), .COLOR_W(CW), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .colors(colors),
        .edge_valid(edge_valid), .edge_ready(rdy2), .edge_u(edge_u),
        .edge_v(edge_v), .edge_last(edge_last), .busy(busy2), .done(done2),
        .valid_coloring(valid2), .conflict_count(cnt2),
        .first_u(fu2), .first_v(fv2), .edge_err(err2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model_sweep(input logic [14:0] c);
        exp_t e;
        int cnt, fu, fv;
        cnt = 0; fu = 0; fv = 0;
        for (int i = 0; i < N; i++)
            for (int j = i + 1; j < N; j++)
                if (c[i*CW +: CW] == c[j*CW +: CW]) begin
                    if (cnt == 0) begin fu = i; fv = j; end
                    cnt++;
                end
        e.res  = {16'(cnt), 3'(fu), 3'(fv), 1'b0, 1'(cnt == 0)};
        e.cnt2 = 2'((cnt > 3) ? 3 : cnt);
        e.lat  = P + 1;
        return e;
    endfunction

    task automatic do_start(input logic m, input logic [14:0] c);
        @(negedge clk);
        start = 1'b1; mode = m; colors = c;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(output int k, output int nb);
        k = -1; nb = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (busy) nb++;
            if (done) begin k = c; break; end
        end
    endtask

    task automatic run_stream(input logic [14:0] c, input int n,
                              input int eu[8], input int ev[8],
                              input int gap, output bit ok);
        exp_t e;
        int cnt, fu, fv;
        bit err, bd, hs;
        cnt = 0; fu = 0; fv = 0; err = 0;
        for (int k = 0; k < n; k++) begin
            bd = (eu[k] == ev[k]) || (eu[k] >= N) || (ev[k] >= N);
            if (bd) err = 1;
            else if (c[eu[k]*CW +: CW] == c[ev[k]*CW +: CW]) begin
                if (cnt == 0) begin fu = eu[k]; fv = ev[k]; end
                cnt++;
            end
        end
        e.res  = {16'(cnt), 3'(fu), 3'(fv), err, 1'((cnt == 0) && !err)};
        e.cnt2 = 2'((cnt > 3) ? 3 : cnt);
        e.lat  = 1;
        sb.push_back(e);
        do_start(1'b1, c);
        ok = 1;
        for (int k = 0; k < n; k++) begin
            edge_u = 3'(eu[k]); edge_v = 3'(ev[k]);
            edge_last = (k == n - 1); edge_valid = 1'b1;
            hs = 0;
            for (int t = 0; t < 10; t++) begin
                @(negedge clk);
                if (edge_ready) begin
                    @(posedge clk);
                    #1 hs = 1;
                    break;
                end
            end
            if (!hs) ok = 0;
            edge_valid = 1'b0; edge_last = 1'b0;
            if (k < n - 1)
                repeat (gap) begin @(posedge clk); #1; end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; mode = 1'b0; colors = '0;
        edge_valid = 1'b0; edge_last = 1'b0; edge_u = '0; edge_v = '0;
        #1;
        total++;
        if ({edge_ready, busy, done, valid_coloring, conflict_count, first_u,
             first_v, edge_err, cnt2} !== '0)
            $display("FAIL reset_outputs got cnt=%0d busy=%b done=%b valid=%b",
                     conflict_count, busy, done, valid_coloring);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_sweep;
        logic [14:0] tbl[4];
        exp_t e;
        int k, nb;
        tbl[0] = {3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
        tbl[1] = {3'd0, 3'd3, 3'd2, 3'd1, 3'd0};
        tbl[2] = {5{3'd5}};
        tbl[3] = {3'd2, 3'd6, 3'd2, 3'd7, 3'd7};
        for (int r = 0; r < 4; r++) begin
            sb.push_back(model_sweep(tbl[r]));
            do_start(1'b0, tbl[r]);
            wait_done(k, nb);
            e = sb.pop_front();
            total++;
            if (k !== e.lat) $display("FAIL sweep%0d_latency got %0d want %0d", r, k, e.lat);
            else passed++;
            total++;
            if (nb !== P) $display("FAIL sweep%0d_busy got %0d want %0d", r, nb, P);
            else passed++;
            total++;
            if ({conflict_count, first_u, first_v, edge_err, valid_coloring} !== e.res)
                $display("FAIL sweep%0d_result got %h want %h", r,
                         {conflict_count, first_u, first_v, edge_err, valid_coloring}, e.res);
            else passed++;
            total++;
            if (cnt2 !== e.cnt2) $display("FAIL sweep%0d_sat got %0d want %0d", r, cnt2, e.cnt2);
            else passed++;
            @(negedge clk);
            total++;
            if ({done, valid_coloring} !== {1'b0, e.res[0]})
                $display("FAIL sweep%0d_hold got %b%b want 0%b", r, done, valid_coloring, e.res[0]);
            else passed++;
        end
    endtask

    task automatic test_stream;
        exp_t e;
        int k, nb;
        bit ok;
        run_stream({3'd2, 3'd3, 3'd1, 3'd2, 3'd1}, 4,
                   '{0, 0, 3, 1, 0, 0, 0, 0}, '{1, 2, 3, 4, 0, 0, 0, 0}, 2, ok);
        total++;
        if (!ok) $display("FAIL stream_handshake got timeout want accept");
        else passed++;
        wait_done(k, nb);
        e = sb.pop_front();
        total++;
        if (k !== e.lat) $display("FAIL stream_latency got %0d want %0d", k, e.lat);
        else passed++;
        total++;
        if ({conflict_count, first_u, first_v, edge_err, valid_coloring} !== e.res)
            $display("FAIL stream_result got %h want %h",
                     {conflict_count, first_u, first_v, edge_err, valid_coloring}, e.res);
        else passed++;
    endtask

    task automatic test_bad_index;
        exp_t e;
        int k, nb;
        bit ok;
        run_stream({3'd2, 3'd3, 3'd1, 3'd2, 3'd1}, 2,
                   '{6, 0, 0, 0, 0, 0, 0, 0}, '{1, 2, 0, 0, 0, 0, 0, 0}, 0, ok);
        total++;
        if (!ok) $display("FAIL badidx_handshake got timeout want accept");
        else passed++;
        wait_done(k, nb);
        e = sb.pop_front();
        total++;
        if (k !== e.lat) $display("FAIL badidx_latency got %0d want %0d", k, e.lat);
        else passed++;
        total++;
        if ({conflict_count, first_u, first_v, edge_err, valid_coloring} !== e.res)
            $display("FAIL badidx_result got %h want %h",
                     {conflict_count, first_u, first_v, edge_err, valid_coloring}, e.res);
        else passed++;
    endtask

    task automatic test_reset_abort;
        exp_t e;
        int k, nb;
        bit seen;
        do_start(1'b0, {5{3'd5}});
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2;
        total++;
        if ({busy, conflict_count} !== {1'b1, 16'd3})
            $display("FAIL abort_live got busy=%b cnt=%0d want busy=1 cnt=3", busy, conflict_count);
        else passed++;
        rst_n = 1'b0;
        #1;
        total++;
        if ({edge_ready, busy, done, valid_coloring, conflict_count, first_u,
             first_v, edge_err, cnt2} !== '0)
            $display("FAIL abort_clear got cnt=%0d busy=%b", conflict_count, busy);
        else passed++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (15) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        total++;
        if (seen) $display("FAIL abort_nodone got done=1 want done=0");
        else passed++;
        sb.push_back(model_sweep({3'd4, 3'd3, 3'd2, 3'd1, 3'd0}));
        do_start(1'b0, {3'd4, 3'd3, 3'd2, 3'd1, 3'd0});
        wait_done(k, nb);
        e = sb.pop_front();
        total++;
        if (k !== e.lat) $display("FAIL restart_latency got %0d want %0d", k, e.lat);
        else passed++;
        total++;
        if ({conflict_count, first_u, first_v, edge_err, valid_coloring} !== e.res)
            $display("FAIL restart_result got %h want %h",
                     {conflict_count, first_u, first_v, edge_err, valid_coloring}, e.res);
        else passed++;
    endtask

    task automatic test_start_while_busy;
        exp_t e;
        int k, nb;
        logic [14:0] c;
        c = {3'd1, 3'd1, 3'd3, 3'd2, 3'd0};
        sb.push_back(model_sweep(c));
        do_start(1'b0, c);
        repeat (2) @(negedge clk);
        start = 1'b1; mode = 1'b1; colors = {5{3'd0}};
        @(posedge clk);
        #1 start = 1'b0; mode = 1'b0; colors = c;
        wait_done(k, nb);
        e = sb.pop_front();
        total++;
        if (k + 2 !== e.lat) $display("FAIL busy_start_latency got %0d want %0d", k + 2, e.lat);
        else passed++;
        total++;
        if ({conflict_count, first_u, first_v, edge_err, valid_coloring} !== e.res)
            $display("FAIL busy_start_result got %h want %h",
                     {conflict_count, first_u, first_v, edge_err, valid_coloring}, e.res);
        else passed++;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        total++;
        if ({busy, done, edge_ready} !== 3'b000)
            $display("FAIL done_start_ignored got busy=%b done=%b rdy=%b want 000",
                     busy, done, edge_ready);
        else passed++;
        @(negedge clk);
        total++;
        if ({busy, valid_coloring} !== {1'b0, e.res[0]})
            $display("FAIL done_start_idle got busy=%b valid=%b want 0%b",
                     busy, valid_coloring, e.res[0]);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_stream();
        test_bad_index();
        test_reset_abort();
        test_start_while_busy();
        total++;
        if (sb.size() !== 0) $display("FAIL scoreboard_drain got %0d want 0", sb.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
